// File: rtl/spi_multilane_tx.sv
// Multi-lane mode-0 SPI serializer with a one-word holding buffer and chip-select framing.
// Define SPI_TX_FRAME_HDR_EN to prepend a 2-bit {last, 0} header to every lane word.
module spi_multilane_tx #(
    parameter int pLANES   = 8,
    parameter int pW_DATA  = 8,
    parameter int pSYS_CLK = 50_000_000,
    parameter int pSPI_CLK = 6_250_000,
    parameter int pCS_GAP  = 4
) (
    input  logic                      iclk,
    input  logic                      irst_n,
    input  logic                      istb,
    output logic                      ordy,
    input  logic                      ilast,
    input  logic [pLANES*pW_DATA-1:0] idata,
    output logic                      spi_clk,
    output logic                      spi_enb,
    output logic [pLANES-1:0]         spi_do,
    output logic                      obusy
);
    localparam int HALF = pSYS_CLK / pSPI_CLK / 2;
`ifdef SPI_TX_FRAME_HDR_EN
    localparam int WL = pW_DATA + 2;
`else
    localparam int WL = pW_DATA;
`endif
    localparam int BW = $clog2(WL + 1);
    localparam int DW = $clog2(HALF + 1);
    localparam int GW = $clog2(pCS_GAP + 1);
    localparam logic [DW-1:0] HALF_M1 = DW'(HALF - 1);
    localparam logic [GW-1:0] GAP_M1  = GW'(pCS_GAP - 1);
    localparam logic [BW-1:0] WL_CNT  = BW'(WL);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_STALL, S_GAP} state_t;

    state_t                        state_q, state_d;
    logic [DW-1:0]                 div_q, div_d;
    logic [BW-1:0]                 bit_q, bit_d;
    logic [GW-1:0]                 gap_q, gap_d;
    logic                          tail_q, tail_d;
    logic [pLANES-1:0][WL-1:0]     sh_q, sh_d;
    logic                          cur_last_q, cur_last_d;
    logic                          spi_clk_q, spi_clk_d;
    logic                          spi_enb_q, spi_enb_d;
    logic [pLANES-1:0]             spi_do_q, spi_do_d;
    logic                          hold_full_q, hold_full_d;
    logic [pLANES*pW_DATA-1:0]     hold_data_q, hold_data_d;
    logic                          hold_last_q, hold_last_d;
    logic                          load;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            tail_q      <= 1'b0;
            sh_q        <= '0;
            cur_last_q  <= 1'b0;
            spi_clk_q   <= 1'b0;
            spi_enb_q   <= 1'b1;
            spi_do_q    <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            tail_q      <= tail_d;
            sh_q        <= sh_d;
            cur_last_q  <= cur_last_d;
            spi_clk_q   <= spi_clk_d;
            spi_enb_q   <= spi_enb_d;
            spi_do_q    <= spi_do_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        tail_d      = tail_q;
        sh_d        = sh_q;
        cur_last_d  = cur_last_q;
        spi_clk_d   = spi_clk_q;
        spi_enb_d   = spi_enb_q;
        spi_do_d    = spi_do_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        load        = 1'b0;

        if (istb && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = idata;
            hold_last_d = ilast;
        end

        unique case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load      = 1'b1;
                    spi_enb_d = 1'b0;
                    div_d     = HALF_M1;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP, S_LOW: begin
                if (div_q == '0) begin
                    // tail_q marks the extra chip-select hold half after a frame's last bit
                    if (tail_q) begin
                        tail_d    = 1'b0;
                        spi_enb_d = 1'b1;
                        spi_do_d  = '0;
                        gap_d     = GAP_M1;
                        state_d   = S_GAP;
                    end else begin
                        spi_clk_d = 1'b1;
                        div_d     = HALF_M1;
                        state_d   = S_HIGH;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            S_HIGH: begin
                if (div_q == '0) begin
                    spi_clk_d = 1'b0;
                    div_d     = HALF_M1;
                    if (bit_q != BW'(1)) begin
                        for (int k = 0; k < pLANES; k++) begin
                            sh_d[k]     = sh_q[k] << 1;
                            spi_do_d[k] = sh_d[k][WL-1];
                        end
                        bit_d   = bit_q - BW'(1);
                        state_d = S_LOW;
                    end else if (cur_last_q) begin
                        tail_d  = 1'b1;
                        state_d = S_LOW;
                    end else if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = S_LOW;
                    end else begin
                        state_d = S_STALL;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            S_STALL: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    div_d   = HALF_M1;
                    state_d = S_SETUP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            hold_full_d = 1'b0;
            cur_last_d  = hold_last_q;
            bit_d       = WL_CNT;
            for (int k = 0; k < pLANES; k++) begin
`ifdef SPI_TX_FRAME_HDR_EN
                sh_d[k] = {hold_last_q, 1'b0, hold_data_q[k*pW_DATA +: pW_DATA]};
`else
                sh_d[k] = hold_data_q[k*pW_DATA +: pW_DATA];
`endif
                spi_do_d[k] = sh_d[k][WL-1];
            end
        end
    end

    assign ordy    = !hold_full_q;
    assign spi_clk = spi_clk_q;
    assign spi_enb = spi_enb_q;
    assign spi_do  = spi_do_q;
    assign obusy   = (state_q != S_IDLE);

endmodule
